wb_stage: RTL and testbench
===========================

# wb_stage

Writeback stage of the 16-bit five-stage pipeline. It holds the MEM/WB pipeline register and selects the value written to the 8-entry register file. It also drives the register-file write port and the forwarding bypass to execute. Its commit outputs are the retire stream probed by the hierarchical testbench, and it owns the halt state plus the cycle and retired-instruction counters.

## Interface
- CNT_W, 32, width of cycle and instruction counters
- clk  in  1  system clock, all flops on rising edge
- rst  in  1  asynchronous reset, active-low (0 = reset)
- valid_M  in  1  instruction present in MEM
- dataMemStall  in  1  data memory not ready; MEM instruction must not advance
- pc_M, instr_M  in  16 each  PC and encoding of MEM instruction
- aluOut_M  in  16  ALU result / memory address
- memRdData_M  in  16  load data
- r2Data_M  in  16  store data
- pcPlus2_M  in  16  link value
- wbSel_M  in  2  writeback source: 0 ALU, 1 MEM, 2 PC+2, 3 reserved (treated as ALU)
- rwen_M  in  1  register write enable
- writeReg_M  in  3  destination register
- memRead_M, memWrite_M, halt_M  in  1 each  instruction class flags
- RWEN_WB  out  1  regfile write enable
- writeRegSel  out  3  regfile write address
- writeData  out  16  regfile write data; also the forwarding value
- commitValid  out  1  instruction retires this cycle
- commitPC, commitInst, commitMemAddr, commitMemData  out  16 each  retire record
- commitMemRead, commitMemWrite, commitHalt  out  1 each  retire record flags
- halted  out  1  sticky, processor stopped
- cycle_count, inst_count  out  CNT_W each  counters

## Operation
- MEM/WB register loads every cycle. Captured valid = valid_M & ~dataMemStall & (state==RUN).
- On a bubble, the valid bit clears and payload flops may hold stale data. Every output qualified by valid is forced to 0 in that case.
- writeData is combinational from registered fields: sel 1 → memRdData, sel 2 → pcPlus2, otherwise aluOut.
- RWEN_WB = valid & rwen. R0 is an ordinary register.
- commitValid = valid. Commit fields are registered copies. commitMemRead, commitMemWrite and commitHalt are ANDed with valid.
- State machine:
  - RUN: a valid halt in WB → HALTED.
  - HALTED: the cycle of transition is the last cycle in which commitValid/commitHalt = 1. From the next cycle, valid_M is ignored, RWEN_WB = 0 and halted = 1 until reset.
- A halt in WB writes no register even if rwen was set. RWEN_WB is gated by ~halt.
- inst_count increments on each commitValid cycle, including the halt.
- cycle_count increments every cycle out of reset while state==RUN. It freezes on entry to HALTED, counting the halt-commit cycle.
- Both counters wrap modulo 2^CNT_W.

## Timing
- Latency: MEM→WB 1 cycle. Regfile write occurs at the clock edge ending the WB cycle. The forwarding value is valid within the WB cycle.
- Reset (rst=0, asynchronous):
  - valid = 0, state = RUN, counters = 0.
  - Outputs: RWEN_WB = 0, writeRegSel = 0, writeData = 0, all commit fields = 0, halted = 0.
- Reset asserted mid-operation discards the in-flight instruction with no write. The first capture after deassertion is at the first rising edge with rst=1.
- dataMemStall=1 with valid_M=1: a bubble enters WB. The instruction commits the cycle after stall drops, exactly once.
- halt_M and dataMemStall both 1: nothing captured. The halt commits one cycle after the stall clears.
- Back-to-back valid instructions commit on consecutive cycles. There is no internal stall.

## Structure
- wb_pkg: WBSEL_ALU=2'd0, WBSEL_MEM=2'd1, WBSEL_PC2=2'd2. Also the state encoding ST_RUN/ST_HALTED and the default CNT_W.
- One sub-module, wb_perf_counters, holds both counters. Its inputs are clk, rst, run, and retire.
- The stage body holds the pipeline register, writeback mux, halt FSM and output gating.

## Test plan
- Reset: drive rst=0 mid-stream with valid_M=1 and rwen_M=1. All outputs are 0 immediately (asynchronous). After release, cycle_count counts 1, 2, 3 …
- ALU, load and link: three consecutive instructions.
  - wbSel=0, aluOut=0x1234, reg 3 → write R3=0x1234, then
  - wbSel=1, memRdData=0xBEEF, reg 5, memRead → R5=0xBEEF with commitMemAddr=aluOut, then
  - wbSel=2, pcPlus2=0x0042, reg 7 → R7=0x0042.
  - inst_count advances by 3.
- Stall: store at pc 0x0010 with dataMemStall high for 3 cycles.
  - Three bubble cycles, each with commitValid=0 and RWEN_WB=0.
  - Then one commit: commitMemWrite=1, commitMemData=r2Data, RWEN_WB=0.
  - inst_count +1 only.
- Halt: halt at pc 0x0020 with rwen_M=1, followed by valid ALU instructions.
  - commitHalt=1 for exactly one cycle with RWEN_WB=0.
  - halted=1 afterwards. Later instructions never commit.
  - cycle_count and inst_count frozen.
- Halt under stall: halt_M=1 and dataMemStall=1 for 2 cycles → commitHalt appears on the 3rd cycle.
- Wrap: CNT_W=4, 17 back-to-back commits → inst_count reads 1.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared definitions for the writeback stage: mux selects, halt FSM states,
// the MEM/WB payload record and the writeback source mux.
package wb_pkg;

  localparam int CNT_W_DEFAULT = 32;

  localparam logic [1:0] WBSEL_ALU = 2'd0;
  localparam logic [1:0] WBSEL_MEM = 2'd1;
  localparam logic [1:0] WBSEL_PC2 = 2'd2;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } wb_state_e;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] instr;
    logic [15:0] alu_out;
    logic [15:0] mem_rd_data;
    logic [15:0] r2_data;
    logic [15:0] pc_plus2;
    logic [1:0]  wb_sel;
    logic        rwen;
    logic [2:0]  write_reg;
    logic        mem_read;
    logic        mem_write;
    logic        halt;
  } wb_payload_t;

  // Reserved select value 3 falls through to the ALU result.
  function automatic logic [15:0] wb_mux(input logic [1:0]  sel,
                                         input logic [15:0] alu_out,
                                         input logic [15:0] mem_rd_data,
                                         input logic [15:0] pc_plus2);
    logic [15:0] v;
    case (sel)
      WBSEL_MEM: v = mem_rd_data;
      WBSEL_PC2: v = pc_plus2;
      default:   v = alu_out;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/wb_if.sv
// MEM-to-WB bus: the MEM-stage instruction record in, the regfile write
// port, forwarding value, retire record, halt flag and counters out.
interface wb_if #(
  parameter int CNT_W = wb_pkg::CNT_W_DEFAULT
);
  logic              valid_M;
  logic              dataMemStall;
  logic [15:0]       pc_M;
  logic [15:0]       instr_M;
  logic [15:0]       aluOut_M;
  logic [15:0]       memRdData_M;
  logic [15:0]       r2Data_M;
  logic [15:0]       pcPlus2_M;
  logic [1:0]        wbSel_M;
  logic              rwen_M;
  logic [2:0]        writeReg_M;
  logic              memRead_M;
  logic              memWrite_M;
  logic              halt_M;

  logic              RWEN_WB;
  logic [2:0]        writeRegSel;
  logic [15:0]       writeData;
  logic              commitValid;
  logic [15:0]       commitPC;
  logic [15:0]       commitInst;
  logic [15:0]       commitMemAddr;
  logic [15:0]       commitMemData;
  logic              commitMemRead;
  logic              commitMemWrite;
  logic              commitHalt;
  logic              halted;
  logic [CNT_W-1:0]  cycle_count;
  logic [CNT_W-1:0]  inst_count;

  modport master (
    output valid_M, dataMemStall, pc_M, instr_M, aluOut_M, memRdData_M,
           r2Data_M, pcPlus2_M, wbSel_M, rwen_M, writeReg_M, memRead_M,
           memWrite_M, halt_M,
    input  RWEN_WB, writeRegSel, writeData, commitValid, commitPC,
           commitInst, commitMemAddr, commitMemData, commitMemRead,
           commitMemWrite, commitHalt, halted, cycle_count, inst_count
  );

  modport slave (
    input  valid_M, dataMemStall, pc_M, instr_M, aluOut_M, memRdData_M,
           r2Data_M, pcPlus2_M, wbSel_M, rwen_M, writeReg_M, memRead_M,
           memWrite_M, halt_M,
    output RWEN_WB, writeRegSel, writeData, commitValid, commitPC,
           commitInst, commitMemAddr, commitMemData, commitMemRead,
           commitMemWrite, commitHalt, halted, cycle_count, inst_count
  );

endinterface

// File: rtl/wb_perf_counters.sv
// Cycle and retired-instruction counters; both wrap modulo 2^CNT_W.
module wb_perf_counters #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             retire,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] inst_count
);

  logic [CNT_W-1:0] r_cycle_count;
  logic [CNT_W-1:0] r_inst_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cycle_count <= '0;
      r_inst_count  <= '0;
    end else begin
      if (run)    r_cycle_count <= r_cycle_count + CNT_W'(1);
      if (retire) r_inst_count  <= r_inst_count + CNT_W'(1);
    end
  end

  assign cycle_count = r_cycle_count;
  assign inst_count  = r_inst_count;

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: MEM/WB register, writeback mux, halt FSM and retire record.
//   state     | meaning
//   ST_RUN    | accepting and retiring instructions, cycle counter running
//   ST_HALTED | halt has retired; nothing accepted, counters frozen until reset
module wb_stage
  import wb_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  wb_if.slave  bus
);

  logic        r_valid;
  wb_payload_t r_pl;
  wb_state_e   r_state;

  logic        w_run;
  logic        w_commit;
  logic        w_halt_wb;
  logic        w_accept;
  logic [15:0] w_wb_data;
  wb_payload_t w_pl_in;

  assign w_run     = (r_state == ST_RUN);
  assign w_commit  = r_valid & w_run;
  assign w_halt_wb = w_commit & r_pl.halt;
  // The instruction behind a retiring halt must never reach WB.
  assign w_accept  = bus.valid_M & ~bus.dataMemStall & w_run & ~w_halt_wb;

  assign w_pl_in = '{
    pc:          bus.pc_M,
    instr:       bus.instr_M,
    alu_out:     bus.aluOut_M,
    mem_rd_data: bus.memRdData_M,
    r2_data:     bus.r2Data_M,
    pc_plus2:    bus.pcPlus2_M,
    wb_sel:      bus.wbSel_M,
    rwen:        bus.rwen_M,
    write_reg:   bus.writeReg_M,
    mem_read:    bus.memRead_M,
    mem_write:   bus.memWrite_M,
    halt:        bus.halt_M
  };

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_pl    <= '0;
      r_state <= ST_RUN;
    end else begin
      r_valid <= w_accept;
      r_pl    <= w_pl_in;
      case (r_state)
        ST_RUN:    if (w_halt_wb) r_state <= ST_HALTED;
        ST_HALTED: r_state <= ST_HALTED;
        default:   r_state <= ST_HALTED;
      endcase
    end
  end

  assign w_wb_data = wb_mux(r_pl.wb_sel, r_pl.alu_out, r_pl.mem_rd_data, r_pl.pc_plus2);

  // Every payload output is zeroed on a bubble so stale flops never leak out.
  assign bus.RWEN_WB        = w_commit & r_pl.rwen & ~r_pl.halt;
  assign bus.writeRegSel    = w_commit ? r_pl.write_reg : 3'd0;
  assign bus.writeData      = w_commit ? w_wb_data      : 16'd0;
  assign bus.commitValid    = w_commit;
  assign bus.commitPC       = w_commit ? r_pl.pc        : 16'd0;
  assign bus.commitInst     = w_commit ? r_pl.instr     : 16'd0;
  assign bus.commitMemAddr  = w_commit ? r_pl.alu_out   : 16'd0;
  assign bus.commitMemData  = w_commit ? r_pl.r2_data   : 16'd0;
  assign bus.commitMemRead  = w_commit & r_pl.mem_read;
  assign bus.commitMemWrite = w_commit & r_pl.mem_write;
  assign bus.commitHalt     = w_halt_wb;
  assign bus.halted         = (r_state == ST_HALTED);

  wb_perf_counters #(.CNT_W(CNT_W)) u_perf (
    .clk         (clk),
    .rst         (rst),
    .run         (w_run),
    .retire      (w_commit),
    .cycle_count (bus.cycle_count),
    .inst_count  (bus.inst_count)
  );

endmodule

// File: tb/tb_wb_stage.sv
// Randomized and directed bench for wb_stage against an instruction-level model.
module tb_wb_stage;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_if #(.CNT_W(32)) u_if ();
  wb_if #(.CNT_W(4))  u_if4 ();

  assign u_if4.valid_M      = u_if.valid_M;
  assign u_if4.dataMemStall = u_if.dataMemStall;
  assign u_if4.pc_M         = u_if.pc_M;
  assign u_if4.instr_M      = u_if.instr_M;
  assign u_if4.aluOut_M     = u_if.aluOut_M;
  assign u_if4.memRdData_M  = u_if.memRdData_M;
  assign u_if4.r2Data_M     = u_if.r2Data_M;
  assign u_if4.pcPlus2_M    = u_if.pcPlus2_M;
  assign u_if4.wbSel_M      = u_if.wbSel_M;
  assign u_if4.rwen_M       = u_if.rwen_M;
  assign u_if4.writeReg_M   = u_if.writeReg_M;
  assign u_if4.memRead_M    = u_if.memRead_M;
  assign u_if4.memWrite_M   = u_if.memWrite_M;
  assign u_if4.halt_M       = u_if.halt_M;

  wb_stage #(.CNT_W(32)) u_dut  (.clk(clk), .rst(rst), .bus(u_if.slave));
  wb_stage #(.CNT_W(4))  u_dut4 (.clk(clk), .rst(rst), .bus(u_if4.slave));

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the instruction sitting in WB, whether the machine has stopped,
  // and how many cycles/instructions have been counted since reset.
  typedef struct {
    logic [15:0] pc, instr, alu, mem, r2, pc2;
    logic [1:0]  sel;
    logic        rwen;
    logic [2:0]  wr;
    logic        mr, mw, halt;
  } rec_t;

  rec_t        m_wb;
  bit          m_valid  = 1'b0;
  bit          m_halted = 1'b0;
  int unsigned m_cyc    = 0;
  int unsigned m_inst   = 0;

  always @(posedge clk or negedge rst) begin : model
    bit halt_retiring;
    if (!rst) begin
      m_valid  = 1'b0;
      m_halted = 1'b0;
      m_cyc    = 0;
      m_inst   = 0;
    end else begin
      if (!m_halted) m_cyc++;
      if (m_valid)   m_inst++;
      halt_retiring = m_valid && m_wb.halt;
      if (halt_retiring) m_halted = 1'b1;
      m_valid = u_if.valid_M && !u_if.dataMemStall && !m_halted;
      m_wb.pc    = u_if.pc_M;       m_wb.instr = u_if.instr_M;
      m_wb.alu   = u_if.aluOut_M;   m_wb.mem   = u_if.memRdData_M;
      m_wb.r2    = u_if.r2Data_M;   m_wb.pc2   = u_if.pcPlus2_M;
      m_wb.sel   = u_if.wbSel_M;    m_wb.rwen  = u_if.rwen_M;
      m_wb.wr    = u_if.writeReg_M; m_wb.mr    = u_if.memRead_M;
      m_wb.mw    = u_if.memWrite_M; m_wb.halt  = u_if.halt_M;
    end
  end

  always @(negedge clk) begin : compare
    logic [15:0] e_wd;
    if (!m_valid)          e_wd = 16'h0;
    else if (m_wb.sel == 2'd1) e_wd = m_wb.mem;
    else if (m_wb.sel == 2'd2) e_wd = m_wb.pc2;
    else                   e_wd = m_wb.alu;
    check("commitValid", 32'(u_if.commitValid), 32'(m_valid));
    check("RWEN_WB", 32'(u_if.RWEN_WB), 32'(m_valid && m_wb.rwen && !m_wb.halt));
    check("writeRegSel", 32'(u_if.writeRegSel), m_valid ? 32'(m_wb.wr) : 32'h0);
    check("writeData", 32'(u_if.writeData), 32'(e_wd));
    check("commitPC", 32'(u_if.commitPC), m_valid ? 32'(m_wb.pc) : 32'h0);
    check("commitInst", 32'(u_if.commitInst), m_valid ? 32'(m_wb.instr) : 32'h0);
    check("commitMemAddr", 32'(u_if.commitMemAddr), m_valid ? 32'(m_wb.alu) : 32'h0);
    check("commitMemData", 32'(u_if.commitMemData), m_valid ? 32'(m_wb.r2) : 32'h0);
    check("commitMemRead", 32'(u_if.commitMemRead), 32'(m_valid && m_wb.mr));
    check("commitMemWrite", 32'(u_if.commitMemWrite), 32'(m_valid && m_wb.mw));
    check("commitHalt", 32'(u_if.commitHalt), 32'(m_valid && m_wb.halt));
    check("halted", 32'(u_if.halted), 32'(m_halted));
    check("cycle_count", u_if.cycle_count, m_cyc);
    check("inst_count", u_if.inst_count, m_inst);
    check("w4_commitValid", 32'(u_if4.commitValid), 32'(m_valid));
    check("w4_writeData", 32'(u_if4.writeData), 32'(e_wd));
    check("w4_cycle_count", 32'(u_if4.cycle_count), m_cyc % 16);
    check("w4_inst_count", 32'(u_if4.inst_count), m_inst % 16);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_instr(input int halt_pct);
    u_if.valid_M      = 1'b1;
    u_if.dataMemStall = 1'b0;
    u_if.pc_M         = 16'($urandom);
    u_if.instr_M      = 16'($urandom);
    u_if.aluOut_M     = 16'($urandom);
    u_if.memRdData_M  = 16'($urandom);
    u_if.r2Data_M     = 16'($urandom);
    u_if.pcPlus2_M    = 16'($urandom);
    u_if.wbSel_M      = 2'($urandom_range(0, 3));
    u_if.rwen_M       = 1'($urandom_range(0, 1));
    u_if.writeReg_M   = 3'($urandom_range(0, 7));
    u_if.memRead_M    = 1'($urandom_range(0, 1));
    u_if.memWrite_M   = 1'($urandom_range(0, 1));
    u_if.halt_M       = ($urandom_range(0, 99) < halt_pct);
  endtask

  task automatic idle();
    rand_instr(0);
    u_if.valid_M = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle();
    step();
    step();
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    idle();
    repeat (3) step();
    check("rst_commitValid", 32'(u_if.commitValid), 'h0);
    check("rst_cycle_count", u_if.cycle_count, 'h0);
    rst = 1'b1;
    step(); check("cyc_after_rst_1", u_if.cycle_count, 'd1);
    step(); check("cyc_after_rst_2", u_if.cycle_count, 'd2);
    step(); check("cyc_after_rst_3", u_if.cycle_count, 'd3);

    // ALU, load, link back to back
    rand_instr(0);
    u_if.wbSel_M = 2'd0; u_if.aluOut_M = 16'h1234; u_if.writeReg_M = 3'd3; u_if.rwen_M = 1'b1;
    step();
    check("alu_wd", 32'(u_if.writeData), 'h1234);
    check("alu_rwen", 32'(u_if.RWEN_WB), 'h1);
    check("alu_reg", 32'(u_if.writeRegSel), 'd3);
    rand_instr(0);
    u_if.wbSel_M = 2'd1; u_if.memRdData_M = 16'hBEEF; u_if.aluOut_M = 16'h0300;
    u_if.writeReg_M = 3'd5; u_if.rwen_M = 1'b1; u_if.memRead_M = 1'b1; u_if.memWrite_M = 1'b0;
    step();
    check("ld_wd", 32'(u_if.writeData), 'hBEEF);
    check("ld_reg", 32'(u_if.writeRegSel), 'd5);
    check("ld_memrd", 32'(u_if.commitMemRead), 'h1);
    check("ld_addr", 32'(u_if.commitMemAddr), 'h0300);
    rand_instr(0);
    u_if.wbSel_M = 2'd2; u_if.pcPlus2_M = 16'h0042; u_if.writeReg_M = 3'd7; u_if.rwen_M = 1'b1;
    step();
    check("lnk_wd", 32'(u_if.writeData), 'h0042);
    check("lnk_reg", 32'(u_if.writeRegSel), 'd7);
    idle();
    step();
    check("seq_inst_count", u_if.inst_count, 'd3);

    // Store held by a 3-cycle data-memory stall
    rand_instr(0);
    u_if.pc_M = 16'h0010; u_if.memWrite_M = 1'b1; u_if.memRead_M = 1'b0;
    u_if.rwen_M = 1'b0; u_if.r2Data_M = 16'hCAFE; u_if.dataMemStall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_cv", 32'(u_if.commitValid), 'h0);
      check("stall_rwen", 32'(u_if.RWEN_WB), 'h0);
    end
    u_if.dataMemStall = 1'b0;
    step();
    check("st_cv", 32'(u_if.commitValid), 'h1);
    check("st_pc", 32'(u_if.commitPC), 'h0010);
    check("st_memwr", 32'(u_if.commitMemWrite), 'h1);
    check("st_data", 32'(u_if.commitMemData), 'hCAFE);
    check("st_rwen", 32'(u_if.RWEN_WB), 'h0);
    idle();
    step();
    check("st_cv_once", 32'(u_if.commitValid), 'h0);
    check("st_inst_count", u_if.inst_count, 'd4);

    // Random traffic without halts
    for (int i = 0; i < 300; i++) begin
      rand_instr(0);
      u_if.dataMemStall = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0) u_if.valid_M = 1'b0;
      step();
    end

    // Reset asserted while a writing instruction sits in WB
    rand_instr(0);
    u_if.rwen_M = 1'b1; u_if.halt_M = 1'b0;
    step();
    #2 rst = 1'b0;
    #1;
    check("mrst_rwen", 32'(u_if.RWEN_WB), 'h0);
    check("mrst_cv", 32'(u_if.commitValid), 'h0);
    check("mrst_wd", 32'(u_if.writeData), 'h0);
    check("mrst_cyc", u_if.cycle_count, 'h0);
    check("mrst_inst", u_if.inst_count, 'h0);
    step();
    rst = 1'b1;
    idle();
    step(); check("mrst_cyc_1", u_if.cycle_count, 'd1);
    step(); check("mrst_cyc_2", u_if.cycle_count, 'd2);
    step(); check("mrst_cyc_3", u_if.cycle_count, 'd3);

    // 17 back-to-back commits wrap the 4-bit instruction counter to 1
    do_reset();
    for (int i = 0; i < 17; i++) begin
      rand_instr(0);
      step();
    end
    idle();
    step();
    check("wrap_inst4", 32'(u_if4.inst_count), 'd1);
    check("wrap_inst32", u_if.inst_count, 'd17);

    // Halt with rwen set, followed by valid ALU instructions
    do_reset();
    rand_instr(0); step();
    rand_instr(0); step();
    rand_instr(0);
    u_if.halt_M = 1'b1; u_if.pc_M = 16'h0020; u_if.rwen_M = 1'b1;
    step();
    check("halt_commit", 32'(u_if.commitHalt), 'h1);
    check("halt_rwen", 32'(u_if.RWEN_WB), 'h0);
    check("halt_pc", 32'(u_if.commitPC), 'h0020);
    check("halt_not_yet", 32'(u_if.halted), 'h0);
    for (int i = 0; i < 6; i++) begin
      rand_instr(0);
      u_if.wbSel_M = 2'd0; u_if.rwen_M = 1'b1;
      step();
      check("post_halt_cv", 32'(u_if.commitValid), 'h0);
      check("post_halt_ch", 32'(u_if.commitHalt), 'h0);
      check("post_halt_halted", 32'(u_if.halted), 'h1);
    end
    check("halt_cyc_frozen", u_if.cycle_count, 'd4);
    check("halt_inst_frozen", u_if.inst_count, 'd3);

    // Halt held in MEM by a 2-cycle stall
    do_reset();
    rand_instr(0);
    u_if.halt_M = 1'b1; u_if.dataMemStall = 1'b1;
    step(); check("hs_cv_1", 32'(u_if.commitValid), 'h0);
    step(); check("hs_cv_2", 32'(u_if.commitValid), 'h0);
    u_if.dataMemStall = 1'b0;
    step();
    check("hs_commit", 32'(u_if.commitHalt), 'h1);
    rand_instr(0);
    step();
    check("hs_halted", 32'(u_if.halted), 'h1);

    // Random traffic with occasional halts, restarted by resets
    for (int r = 0; r < 4; r++) begin
      do_reset();
      for (int i = 0; i < 80; i++) begin
        rand_instr(3);
        u_if.dataMemStall = ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 7) == 0) u_if.valid_M = 1'b0;
        step();
      end
    end

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
